// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD image controller: command codes, controller
// state encoding and the address-width helper.
package lcd_ctrl_pkg;

   // Host command codes
   localparam logic [3:0] CMD_WRITE    = 4'h0;
   localparam logic [3:0] CMD_UP       = 4'h1;
   localparam logic [3:0] CMD_DOWN     = 4'h2;
   localparam logic [3:0] CMD_LEFT     = 4'h3;
   localparam logic [3:0] CMD_RIGHT    = 4'h4;
   localparam logic [3:0] CMD_MAX      = 4'h5;
   localparam logic [3:0] CMD_MIN      = 4'h6;
   localparam logic [3:0] CMD_AVG      = 4'h7;
   localparam logic [3:0] CMD_ROT_CCW  = 4'h8;
   localparam logic [3:0] CMD_ROT_CW   = 4'h9;
   localparam logic [3:0] CMD_MIRROR_X = 4'hA;
   localparam logic [3:0] CMD_MIRROR_Y = 4'hB;
   localparam logic [3:0] CMD_RELOAD   = 4'hC;

   // Controller states
   typedef enum logic [1:0] {
      StLoad,
      StIdle,
      StExec,
      StWrite
   } state_e;

   // Pixel address width for a 2**w_log2 x 2**h_log2 image (address = Y*W + X)
   function automatic int unsigned addr_w(input int unsigned w_log2, input int unsigned h_log2);
      return w_log2 + h_log2;
   endfunction

endpackage

// File: rtl/lcd_window_alu.sv
// Combinational reduction over the four pixels of the 2x2 operation window:
// maximum, minimum and floor of the average.
module lcd_window_alu #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] tl_i,
   input  logic [DATA_W-1:0] tr_i,
   input  logic [DATA_W-1:0] bl_i,
   input  logic [DATA_W-1:0] br_i,
   output logic [DATA_W-1:0] max_o,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] avg_o
);

   logic [DATA_W-1:0] max_top, max_bot;
   logic [DATA_W-1:0] min_top, min_bot;
   logic [DATA_W+1:0] sum;

   // Pairwise max/min tree and a 2-bit-wider sum so the average never overflows
   always_comb begin
      max_top = (tl_i > tr_i) ? tl_i : tr_i;
      max_bot = (bl_i > br_i) ? bl_i : br_i;
      min_top = (tl_i < tr_i) ? tl_i : tr_i;
      min_bot = (bl_i < br_i) ? bl_i : br_i;
      max_o   = (max_top > max_bot) ? max_top : max_bot;
      min_o   = (min_top < min_bot) ? min_top : min_bot;
      sum     = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
      avg_o   = sum[DATA_W+1:2];
   end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads a W x H image from IROM into a local pixel array,
// edits the 2x2 window around a movable operation point on host commands, and
// streams the whole image to IRAM on WRITE, pulsing done when finished.
module lcd_ctrl_param
   import lcd_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned IMG_W_LOG2 = 3,
   parameter int unsigned IMG_H_LOG2 = 3,
   localparam int unsigned ADDR_W    = addr_w(IMG_W_LOG2, IMG_H_LOG2)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        cmd,
   input  logic              cmd_valid,
   input  logic [DATA_W-1:0] IROM_Q,
   output logic              IROM_rd,
   output logic [ADDR_W-1:0] IROM_A,
   output logic              IRAM_valid,
   output logic [DATA_W-1:0] IRAM_D,
   output logic [ADDR_W-1:0] IRAM_A,
   output logic              busy,
   output logic              done
);

   localparam int unsigned N = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0]     AddrLast = '1;
   localparam logic [ADDR_W-1:0]     AddrZero = '0;
   localparam logic [IMG_W_LOG2-1:0] XMax     = '1;
   localparam logic [IMG_H_LOG2-1:0] YMax     = '1;
   localparam logic [IMG_W_LOG2-1:0] XMin     = IMG_W_LOG2'(1);
   localparam logic [IMG_H_LOG2-1:0] YMin     = IMG_H_LOG2'(1);
   localparam logic [IMG_W_LOG2-1:0] XInit    = IMG_W_LOG2'(2 ** (IMG_W_LOG2 - 1));
   localparam logic [IMG_H_LOG2-1:0] YInit    = IMG_H_LOG2'(2 ** (IMG_H_LOG2 - 1));

   // Pixel storage; deliberately not reset, it is always refilled by LOAD
   logic [DATA_W-1:0] image_q [N];

   state_e                state_q, state_d;
   logic [IMG_W_LOG2-1:0] x_q, x_d;
   logic [IMG_H_LOG2-1:0] y_q, y_d;
   logic [3:0]            cmd_q, cmd_d;
   logic                  rom_rd_q, rom_rd_d;
   logic [ADDR_W-1:0]     rom_a_q, rom_a_d;
   logic                  ram_valid_q, ram_valid_d;
   logic [DATA_W-1:0]     ram_d_q, ram_d_d;
   logic [ADDR_W-1:0]     ram_a_q, ram_a_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Window geometry: the op point is the bottom-right corner of the window
   logic [IMG_W_LOG2-1:0] x_m1;
   logic [IMG_H_LOG2-1:0] y_m1;
   logic [ADDR_W-1:0]     addr_tl, addr_tr, addr_bl, addr_br;
   logic [DATA_W-1:0]     px_tl, px_tr, px_bl, px_br;
   logic [DATA_W-1:0]     win_max, win_min, win_avg;
   logic [DATA_W-1:0]     new_tl, new_tr, new_bl, new_br;
   logic                  win_we;
   logic                  load_we;
   logic [ADDR_W-1:0]     ram_a_inc;

   // Window addresses and current window pixels
   always_comb begin
      x_m1    = x_q - 1'b1;
      y_m1    = y_q - 1'b1;
      addr_tl = {y_m1, x_m1};
      addr_tr = {y_m1, x_q};
      addr_bl = {y_q, x_m1};
      addr_br = {y_q, x_q};
      px_tl   = image_q[addr_tl];
      px_tr   = image_q[addr_tr];
      px_bl   = image_q[addr_bl];
      px_br   = image_q[addr_br];
   end

   lcd_window_alu #(
      .DATA_W (DATA_W)
   ) u_window_alu (
      .tl_i  (px_tl),
      .tr_i  (px_tr),
      .bl_i  (px_bl),
      .br_i  (px_br),
      .max_o (win_max),
      .min_o (win_min),
      .avg_o (win_avg)
   );

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StLoad;
         x_q         <= XInit;
         y_q         <= YInit;
         cmd_q       <= CMD_WRITE;
         rom_rd_q    <= 1'b1;
         rom_a_q     <= '0;
         ram_valid_q <= 1'b0;
         ram_d_q     <= '0;
         ram_a_q     <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cmd_q       <= cmd_d;
         rom_rd_q    <= rom_rd_d;
         rom_a_q     <= rom_a_d;
         ram_valid_q <= ram_valid_d;
         ram_d_q     <= ram_d_d;
         ram_a_q     <= ram_a_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state, output and window-update decode
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      cmd_d       = cmd_q;
      rom_rd_d    = rom_rd_q;
      rom_a_d     = rom_a_q;
      ram_valid_d = ram_valid_q;
      ram_d_d     = ram_d_q;
      ram_a_d     = ram_a_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      win_we      = 1'b0;
      new_tl      = px_tl;
      new_tr      = px_tr;
      new_bl      = px_bl;
      new_br      = px_br;
      load_we     = 1'b0;
      ram_a_inc   = ram_a_q + 1'b1;

      unique case (state_q)
         StLoad: begin
            load_we = 1'b1;
            rom_a_d = rom_a_q + 1'b1;
            if (rom_a_q == AddrLast) begin
               rom_rd_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = StIdle;
            end
         end

         StIdle: begin
            if (cmd_valid && !busy_q) begin
               cmd_d  = cmd;
               busy_d = 1'b1;
               if (cmd == CMD_WRITE) begin
                  // First beat goes out on the accepting edge so WRITE lasts N cycles
                  ram_valid_d = 1'b1;
                  ram_a_d     = AddrZero;
                  ram_d_d     = image_q[AddrZero];
                  state_d     = StWrite;
               end else begin
                  state_d = StExec;
               end
            end
         end

         StExec: begin
            busy_d  = 1'b0;
            state_d = StIdle;
            unique case (cmd_q)
               CMD_UP:    if (y_q > YMin) y_d = y_q - 1'b1;
               CMD_DOWN:  if (y_q < YMax) y_d = y_q + 1'b1;
               CMD_LEFT:  if (x_q > XMin) x_d = x_q - 1'b1;
               CMD_RIGHT: if (x_q < XMax) x_d = x_q + 1'b1;
               CMD_MAX: begin
                  win_we = 1'b1;
                  new_tl = win_max;
                  new_tr = win_max;
                  new_bl = win_max;
                  new_br = win_max;
               end
               CMD_MIN: begin
                  win_we = 1'b1;
                  new_tl = win_min;
                  new_tr = win_min;
                  new_bl = win_min;
                  new_br = win_min;
               end
               CMD_AVG: begin
                  win_we = 1'b1;
                  new_tl = win_avg;
                  new_tr = win_avg;
                  new_bl = win_avg;
                  new_br = win_avg;
               end
               CMD_ROT_CCW: begin
                  win_we = 1'b1;
                  new_tl = px_tr;
                  new_tr = px_br;
                  new_br = px_bl;
                  new_bl = px_tl;
               end
               CMD_ROT_CW: begin
                  win_we = 1'b1;
                  new_tl = px_bl;
                  new_bl = px_br;
                  new_br = px_tr;
                  new_tr = px_tl;
               end
               CMD_MIRROR_X: begin
                  win_we = 1'b1;
                  new_tl = px_bl;
                  new_bl = px_tl;
                  new_tr = px_br;
                  new_br = px_tr;
               end
               CMD_MIRROR_Y: begin
                  win_we = 1'b1;
                  new_tl = px_tr;
                  new_tr = px_tl;
                  new_bl = px_br;
                  new_br = px_bl;
               end
               CMD_RELOAD: begin
                  rom_rd_d = 1'b1;
                  rom_a_d  = AddrZero;
                  x_d      = XInit;
                  y_d      = YInit;
                  busy_d   = 1'b1;
                  state_d  = StLoad;
               end
               default: ;  // D-F are NOPs
            endcase
         end

         StWrite: begin
            if (ram_a_q == AddrLast) begin
               ram_valid_d = 1'b0;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = StIdle;
            end else begin
               ram_a_d = ram_a_inc;
               ram_d_d = image_q[ram_a_inc];
            end
         end

         default: state_d = StLoad;
      endcase
   end

   // Pixel array writes: ROM fill during LOAD, window update on EXEC
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (load_we) begin
            image_q[rom_a_q] <= IROM_Q;
         end
         if (win_we) begin
            image_q[addr_tl] <= new_tl;
            image_q[addr_tr] <= new_tr;
            image_q[addr_bl] <= new_bl;
            image_q[addr_br] <= new_br;
         end
      end
   end

   assign IROM_rd    = rom_rd_q;
   assign IROM_A     = rom_a_q;
   assign IRAM_valid = ram_valid_q;
   assign IRAM_D     = ram_d_q;
   assign IRAM_A     = ram_a_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: a command-level image model predicts every output
// each cycle; directed scenarios pin the model with hand-computed pixel values,
// then a randomized phase exercises commands, reloads and resets.
module tb_lcd_ctrl_param;

   localparam int W = 8;
   localparam int H = 8;
   localparam int N = W * H;

   logic       clk;
   logic       reset;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] IROM_Q;
   logic       IROM_rd;
   logic [5:0] IROM_A;
   logic       IRAM_valid;
   logic [7:0] IRAM_D;
   logic [5:0] IRAM_A;
   logic       busy;
   logic       done;

   lcd_ctrl_param #(
      .DATA_W     (8),
      .IMG_W_LOG2 (3),
      .IMG_H_LOG2 (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .IROM_Q     (IROM_Q),
      .IROM_rd    (IROM_rd),
      .IROM_A     (IROM_A),
      .IRAM_valid (IRAM_valid),
      .IRAM_D     (IRAM_D),
      .IRAM_A     (IRAM_A),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents shared by the ROM model and the reference model
   logic [7:0] m_rom [N];
   assign IROM_Q = m_rom[IROM_A];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_img [N];
   int   m_px, m_py;
   bit   m_init = 0;
   bit   m_loading, m_writing, m_exec, m_ad_known;
   int   m_ld, m_wk;
   logic [3:0] m_ecmd;
   logic exp_busy, exp_done, exp_valid, exp_rom_rd;
   logic [5:0] exp_rom_a, exp_iram_a;
   logic [7:0] exp_iram_d;

   task automatic model_apply(input logic [3:0] c);
      int idx [4];
      int v [4];
      int nv [4];
      int acc;
      idx[0] = (m_py - 1) * W + (m_px - 1);
      idx[1] = (m_py - 1) * W + m_px;
      idx[2] = m_py * W + (m_px - 1);
      idx[3] = m_py * W + m_px;
      for (int i = 0; i < 4; i++) v[i] = int'(m_img[idx[i]]);
      for (int i = 0; i < 4; i++) nv[i] = v[i];
      case (c)
         4'h1: if (m_py > 1) m_py--;
         4'h2: if (m_py < H - 1) m_py++;
         4'h3: if (m_px > 1) m_px--;
         4'h4: if (m_px < W - 1) m_px++;
         4'h5: begin
            acc = 0;
            for (int i = 0; i < 4; i++) if (v[i] > acc) acc = v[i];
            for (int i = 0; i < 4; i++) nv[i] = acc;
         end
         4'h6: begin
            acc = 1 << 30;
            for (int i = 0; i < 4; i++) if (v[i] < acc) acc = v[i];
            for (int i = 0; i < 4; i++) nv[i] = acc;
         end
         4'h7: begin
            acc = (v[0] + v[1] + v[2] + v[3]) / 4;
            for (int i = 0; i < 4; i++) nv[i] = acc;
         end
         4'h8: begin nv[0] = v[1]; nv[1] = v[3]; nv[3] = v[2]; nv[2] = v[0]; end
         4'h9: begin nv[0] = v[2]; nv[2] = v[3]; nv[3] = v[1]; nv[1] = v[0]; end
         4'hA: begin nv[0] = v[2]; nv[2] = v[0]; nv[1] = v[3]; nv[3] = v[1]; end
         4'hB: begin nv[0] = v[1]; nv[1] = v[0]; nv[2] = v[3]; nv[3] = v[2]; end
         default: ;
      endcase
      for (int i = 0; i < 4; i++) m_img[idx[i]] = 8'(nv[i]);
   endtask

   task automatic model_step();
      if (reset === 1'b1) begin
         m_init     = 1;
         m_loading  = 1;
         m_ld       = 0;
         m_writing  = 0;
         m_exec     = 0;
         m_px       = W / 2;
         m_py       = H / 2;
         exp_busy   = 1'b1;
         exp_done   = 1'b0;
         exp_valid  = 1'b0;
         exp_rom_rd = 1'b1;
         exp_rom_a  = '0;
         exp_iram_a = '0;
         exp_iram_d = '0;
         m_ad_known = 1;
         return;
      end
      if (!m_init) return;
      exp_done = 1'b0;
      if (m_loading) begin
         m_img[m_ld] = m_rom[m_ld];
         if (m_ld == N - 1) begin
            m_loading  = 0;
            m_ld       = 0;
            exp_rom_rd = 1'b0;
            exp_busy   = 1'b0;
         end else begin
            m_ld++;
         end
         exp_rom_a = 6'(m_ld);
      end else if (m_writing) begin
         if (m_wk == N - 1) begin
            m_writing  = 0;
            exp_valid  = 1'b0;
            exp_done   = 1'b1;
            exp_busy   = 1'b0;
            m_ad_known = 0;
         end else begin
            m_wk++;
            exp_iram_a = 6'(m_wk);
            exp_iram_d = m_img[m_wk];
         end
      end else if (m_exec) begin
         m_exec = 0;
         if (m_ecmd == 4'hC) begin
            m_loading  = 1;
            m_ld       = 0;
            exp_rom_rd = 1'b1;
            exp_rom_a  = '0;
            m_px       = W / 2;
            m_py       = H / 2;
         end else begin
            model_apply(m_ecmd);
            exp_busy = 1'b0;
         end
      end else if (cmd_valid === 1'b1 && exp_busy === 1'b0) begin
         exp_busy = 1'b1;
         if (cmd == 4'h0) begin
            m_writing  = 1;
            m_wk       = 0;
            exp_valid  = 1'b1;
            exp_iram_a = '0;
            exp_iram_d = m_img[0];
         end else begin
            m_exec = 1;
            m_ecmd = cmd;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      if (m_init) begin
         check("busy", busy, exp_busy);
         check("done", done, exp_done);
         check("IRAM_valid", IRAM_valid, exp_valid);
         check("IROM_rd", IROM_rd, exp_rom_rd);
         check("IROM_A", IROM_A, exp_rom_a);
         if (exp_valid === 1'b1 || m_ad_known) begin
            check("IRAM_A", IRAM_A, exp_iram_a);
            check("IRAM_D", IRAM_D, exp_iram_d);
         end
      end
   end

   // IRAM capture and done-pulse counting
   logic [7:0] iram_mem [N];
   int done_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (IRAM_valid === 1'b1) iram_mem[IRAM_A] = IRAM_D;
      if (done === 1'b1) done_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle(input string what);
      int n = 0;
      while (exp_busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({what, "_idle"}, busy, 1'b0);
   endtask

   task automatic do_reset(input bit rand_rom);
      int n = 0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      for (int i = 0; i < N; i++) m_rom[i] = rand_rom ? 8'($urandom_range(0, 255)) : 8'(i);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("load_cycles", n, N);
   endtask

   task automatic send_cmd(input logic [3:0] c);
      wait_idle("pre_cmd");
      cmd_valid = 1'b1;
      cmd       = c;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_write();
      for (int i = 0; i < N; i++) iram_mem[i] = 'x;
      done_cnt = 0;
      send_cmd(4'h0);
      wait_idle("write");
      @(negedge clk);
      check("done_pulses", done_cnt, 1);
   endtask

   task automatic check_against_model(input string what);
      int bad = 0;
      for (int i = 0; i < N; i++) if (iram_mem[i] !== m_img[i]) bad++;
      check(what, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- scenarios ----------------
   initial begin
      int bad;
      int busy_hi;
      int n;
      logic [3:0] c;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd       = 4'h0;

      // Ramp ROM, load then write back the ramp
      do_reset(0);
      do_write();
      bad = 0;
      for (int i = 0; i < N; i++) if (iram_mem[i] !== 8'(i)) bad++;
      check("ramp_write", bad, 0);

      // AVG at (4,4): window 27,28,35,36 -> 126/4 = 31
      send_cmd(4'h7);
      do_write();
      check("avg_27", iram_mem[27], 31);
      check("avg_28", iram_mem[28], 31);
      check("avg_35", iram_mem[35], 31);
      check("avg_36", iram_mem[36], 31);
      check("avg_26_kept", iram_mem[26], 26);
      check("avg_44_kept", iram_mem[44], 44);

      // MAX at (4,4) -> 36
      do_reset(0);
      send_cmd(4'h5);
      do_write();
      check("max_27", iram_mem[27], 36);
      check("max_36", iram_mem[36], 36);

      // Five left shifts saturate at X=1: window 24,25,32,33 -> max 33
      do_reset(0);
      for (int i = 0; i < 5; i++) send_cmd(4'h3);
      send_cmd(4'h5);
      do_write();
      check("sat_24", iram_mem[24], 33);
      check("sat_25", iram_mem[25], 33);
      check("sat_32", iram_mem[32], 33);
      check("sat_33", iram_mem[33], 33);
      check("sat_26_kept", iram_mem[26], 26);

      // CW then CCW restores; mirror X swaps rows
      do_reset(0);
      send_cmd(4'h9);
      send_cmd(4'h8);
      do_write();
      check("rot_27", iram_mem[27], 27);
      check("rot_28", iram_mem[28], 28);
      check("rot_35", iram_mem[35], 35);
      check("rot_36", iram_mem[36], 36);
      send_cmd(4'hA);
      do_write();
      check("mirx_27", iram_mem[27], 35);
      check("mirx_35", iram_mem[35], 27);
      check("mirx_28", iram_mem[28], 36);
      check("mirx_36", iram_mem[36], 28);

      // Held cmd_valid: one accept per busy-low cycle -> busy high every other cycle
      wait_idle("hold");
      cmd_valid = 1'b1;
      cmd       = 4'h5;
      busy_hi   = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_hi++;
      end
      cmd_valid = 1'b0;
      check("hold_busy_cycles", busy_hi, 10);

      // Commands held during WRITE are ignored
      wait_idle("wr_hold");
      cmd_valid = 1'b1;
      cmd       = 4'h0;
      @(negedge clk);
      cmd = 4'h7;
      n = 0;
      while (exp_busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      do_write();
      check_against_model("write_ignores_cmds");

      // Reset at write index 20, then reload and write back the ROM
      send_cmd(4'h0);
      n = 0;
      while (!(exp_valid === 1'b1 && exp_iram_a == 6'd20) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wr20_reached", IRAM_A, 20);
      do_reset(0);
      do_write();
      bad = 0;
      for (int i = 0; i < N; i++) if (iram_mem[i] !== 8'(i)) bad++;
      check("after_reset_write", bad, 0);

      // Randomized commands on a random image, with occasional reset
      do_reset(1);
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) begin
            reset     = 1'b1;
            cmd_valid = 1'b0;
         end else begin
            reset     = 1'b0;
            c         = 4'($urandom_range(0, 15));
            if ((c == 4'h0 || c == 4'hC) && $urandom_range(0, 3) != 0) c = 4'h7;
            cmd       = c;
            cmd_valid = ($urandom_range(0, 1) == 1);
         end
      end
      @(negedge clk);
      reset     = 1'b0;
      cmd_valid = 1'b0;
      wait_idle("rand_end");
      do_write();
      check_against_model("rand_final_image");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
